// File: rtl/fpcvt_reg_if.sv
// fpcvt_reg_if: data bundle for the registered integer-to-float converter.
//   D : 12-bit two's-complement integer into the converter
//   S : sign bit of the result
//   E : 3-bit exponent of the result
//   F : 4-bit significand of the result
// master drives D and observes the result; slave is the converter itself.
interface fpcvt_reg_if;
  logic [11:0] D;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;

  modport master (output D, input S, E, F);
  modport slave  (input D, output S, E, F);
endinterface

// File: rtl/fpcvt_reg.sv
// fpcvt_reg: converts a 12-bit two's-complement integer into an 8-bit
// sign/magnitude float code (-1)^S * F * 2^E with a single register stage.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears S/E/F
//   bus   : fpcvt_reg_if.slave (D in; S, E, F out, registered)
module fpcvt_reg (
  input  logic         clk,
  input  logic         rst_n,
  fpcvt_reg_if.slave   bus
);

  logic [11:0] mag;
  logic [3:0]  lz;
  logic [11:0] norm;
  logic [2:0]  e0;
  logic [3:0]  f0;
  logic        r0;
  logic [2:0]  e_n;
  logic [3:0]  f_n;

  // -2048 has no positive counterpart in 12 bits, so it clamps to 2047.
  always_comb begin
    mag = bus.D;
    if (bus.D[11]) begin
      if (bus.D == 12'h800) mag = 12'h7FF;
      else                  mag = 12'(~bus.D + 12'd1);
    end
  end

  // Highest set bit wins, giving the leading-zero count; zero input yields 12.
  always_comb begin
    lz = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (mag[i]) lz = 4'(11 - i);
    end
  end

  // Normalising the leading one to bit 11 puts the significand in [11:8]
  // and the round bit at [7].
  assign norm = mag << lz;

  always_comb begin
    if (lz < 4'd8) begin
      e0 = 3'(4'd8 - lz);
      f0 = norm[11:8];
      r0 = norm[7];
    end else begin
      e0 = 3'd0;
      f0 = mag[3:0];
      r0 = 1'b0;
    end
  end

  always_comb begin
    e_n = e0;
    f_n = f0;
    if (r0) begin
      if (f0 != 4'hF) begin
        f_n = f0 + 4'd1;
      end else if (e0 != 3'd7) begin
        f_n = 4'b1000;
        e_n = e0 + 3'd1;
      end else begin
        f_n = 4'hF;
        e_n = 3'd7;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.S <= 1'b0;
      bus.E <= 3'd0;
      bus.F <= 4'd0;
    end else begin
      bus.S <= bus.D[11];
      bus.E <= e_n;
      bus.F <= f_n;
    end
  end

endmodule

// File: tb/tb_fpcvt_reg.sv
module tb_fpcvt_reg;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [7:0] sb_q[$];

  fpcvt_reg_if bus ();

  fpcvt_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: exponent from the position of the highest set bit.
  function automatic logic [7:0] ref_code(input logic [11:0] d);
    int v, mag, p, e, f, r;
    v = int'($signed(d));
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    if (mag < 16) return {d[11], 3'd0, 4'(mag)};
    p = 0;
    for (int i = 0; i < 12; i++) if (((mag >> i) & 1) == 1) p = i;
    e = p - 3;
    f = mag >> e;
    r = (mag >> (e - 1)) & 1;
    if (r == 1) begin
      if (f < 15) f = f + 1;
      else if (e < 7) begin f = 8; e = e + 1; end
      else begin f = 15; e = 7; end
    end
    return {d[11], 3'(e), 4'(f)};
  endfunction

  function automatic logic [7:0] dut_code();
    return {bus.S, bus.E, bus.F};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b_%b_%b expected=%b_%b_%b", tag,
             obs[7], obs[6:4], obs[3:0], exp[7], exp[6:4], exp[3:0]);
    end
  endtask

  // Drive D on the falling edge, queue the model result, compare after the rising edge.
  task automatic step(input logic [11:0] d, input string tag);
    logic [7:0] exp;
    @(negedge clk);
    bus.D = d;
    sb_q.push_back(ref_code(d));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty observed=%b", tag, dut_code());
    end else begin
      exp = sb_q.pop_front();
      check(tag, dut_code(), exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.D  = 12'h5A5;
    #1;
    check("reset_immediate", dut_code(), 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", dut_code(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    step(12'h000, "zero");
    check("zero_const", dut_code(), 8'b0_000_0000);

    // Latency: D changes before the edge but the output must not move yet.
    @(negedge clk);
    bus.D = 12'h1A6;
    sb_q.push_back(ref_code(12'h1A6));
    #3;
    check("latency_before_edge", dut_code(), 8'b0_000_0000);
    @(posedge clk);
    #1;
    check("pos422", dut_code(), sb_q.pop_front());
    check("pos422_const", dut_code(), 8'b0_101_1101);

    step(12'(-422), "neg422");
    check("neg422_const", dut_code(), 8'b1_101_1101);
    step(12'h07D, "d125");
    check("d125_const", dut_code(), 8'b0_100_1000);
    step(12'h01F, "d31");
    check("d31_const", dut_code(), 8'b0_010_1000);
    step(12'd15, "d15");
    check("d15_const", dut_code(), 8'b0_000_1111);
    step(12'hFFF, "neg1");
    check("neg1_const", dut_code(), 8'b1_000_0001);
    step(12'h7FF, "d2047");
    check("d2047_const", dut_code(), 8'b0_111_1111);
    step(12'h800, "neg2048");
    check("neg2048_const", dut_code(), 8'b1_111_1111);
    step(12'd1920, "d1920");
    check("d1920_const", dut_code(), 8'b0_111_1111);
    step(12'd1919, "d1919");
    check("d1919_const", dut_code(), 8'b0_111_1111);
    step(12'd16, "d16");
    check("d16_const", dut_code(), 8'b0_001_1000);

    for (int i = 0; i < 4096; i++) begin
      step(12'(i), $sformatf("sweep_%03h", i));
      if (i == 2000) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", dut_code(), 8'h00);
        #1;
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
